coax_rx_byte_packer: RTL and testbench

- Downstream consumer of coax_buffered_rx.
- Pops received 10-bit coax words from the buffered receiver's first-word-fall-through FIFO and serialises each word into two bytes on a valid/ready byte stream toward the host interface.
- Converts a receiver error into a single flagged error record.
- Keeps a running count of words delivered.

---
 rtl/coax_rx_byte_packer.sv | 108 ++++++++++
 tb/tb_coax_rx_byte_packer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coax_rx_byte_packer.sv
// Pops 10-bit coax words from the buffered receiver FIFO and sends each as a hi/lo byte pair
// on a valid/ready stream; a receiver error becomes one flagged record followed by a halt.
module coax_rx_byte_packer #(
  parameter int DATA_WIDTH  = 10,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_empty,
  input  logic                   rx_error,
  output logic                   rx_read_strobe,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] words_count,
  output logic                   halted,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_HI = 3'd1,
    SEND_LO = 3'd2,
    ERR_HI  = 3'd3,
    ERR_LO  = 3'd4,
    HALT    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [7:0]             hi_byte;
  logic [7:0]             lo_byte;

  // Upper data bits sit right-justified in the hi byte; bit 7 is reserved for the error flag.
  assign hi_byte = 8'(word_q >> 8);
  assign lo_byte = word_q[7:0];

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    count_d        = count_q;
    rx_read_strobe = 1'b0;
    out_valid      = 1'b0;
    out_data       = 8'h00;

    case (state_q)
      IDLE: begin
        if (rx_error) begin
          word_d  = rx_data;
          state_d = ERR_HI;
        end else if (!rx_empty) begin
          word_d         = rx_data;
          rx_read_strobe = 1'b1;
          state_d        = SEND_HI;
        end
      end
      SEND_HI: begin
        out_valid = 1'b1;
        out_data  = hi_byte;
        if (out_ready) state_d = SEND_LO;
      end
      SEND_LO: begin
        out_valid = 1'b1;
        out_data  = lo_byte;
        if (out_ready) begin
          count_d = count_q + 1'b1;
          state_d = IDLE;
        end
      end
      ERR_HI: begin
        out_valid = 1'b1;
        out_data  = hi_byte | 8'h80;
        if (out_ready) state_d = ERR_LO;
      end
      ERR_LO: begin
        out_valid = 1'b1;
        out_data  = lo_byte;
        if (out_ready) state_d = HALT;
      end
      HALT: begin
        if (!rx_error) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A pop during reset would lose a word the receiver believes was consumed.
    if (reset) rx_read_strobe = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
    end
  end

  assign words_count = count_q;
  assign halted      = (state_q == HALT);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_coax_rx_byte_packer.sv
// Self-checking bench: a queue models the receiver FIFO and the expected byte stream is
// built from the record format rules, then compared with the bytes the host side accepts.
module tb_coax_rx_byte_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rx_data;
  logic        rx_empty;
  logic        rx_error;
  logic        rx_read_strobe;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] words_count;
  logic        halted;
  logic        busy;

  always #5 clk = ~clk;

  coax_rx_byte_packer #(.DATA_WIDTH(10), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_error(rx_error),
    .rx_read_strobe(rx_read_strobe), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .words_count(words_count), .halted(halted), .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [9:0] fifo[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [9:0] err_code = 10'h000;
  int model_wc = 0;
  int strobes = 0;
  int strobe_empty_viol = 0;
  int reset_strobe_viol = 0;
  int stable_viol = 0;
  int gap_viol = 0;
  int hs_parity = 0;
  bit gap_pending = 0;
  bit hold_pending = 0;
  logic [7:0] hold_data = 8'h00;

  function automatic logic [7:0] hi_of(input logic [9:0] w, input bit err);
    int v;
    v = int'(w) / 256 + (err ? 128 : 0);
    return 8'(v);
  endfunction

  task automatic expect_word(input logic [9:0] w, input bit err);
    exp_q.push_back(hi_of(w, err));
    exp_q.push_back(w[7:0]);
    if (!err) model_wc++;
  endtask

  task automatic drive_inputs();
    rx_empty = (fifo.size() == 0);
    if (rx_error) rx_data = err_code;
    else if (fifo.size() != 0) rx_data = fifo[0];
    else rx_data = 10'($urandom);
  endtask

  // One clock: observe outputs at the falling edge, advance, then update the FIFO model.
  task automatic step();
    bit pop;
    @(negedge clk);
    pop = 0;
    if (reset) begin
      if (rx_read_strobe === 1'b1) reset_strobe_viol++;
      gap_pending = 0;
      hold_pending = 0;
      hs_parity = 0;
    end else begin
      if (rx_read_strobe === 1'b1) begin
        strobes++;
        pop = 1;
        if (rx_empty) strobe_empty_viol++;
      end
      if (gap_pending && out_valid === 1'b1) gap_viol++;
      gap_pending = 0;
      if (hold_pending && (out_valid !== 1'b1 || out_data !== hold_data)) stable_viol++;
      hold_pending = (out_valid === 1'b1) && !out_ready;
      hold_data = out_data;
      if (out_valid === 1'b1 && out_ready) begin
        got.push_back(out_data);
        hs_parity ^= 1;
        if (hs_parity == 0) gap_pending = 1;
      end
    end
    @(posedge clk);
    #1;
    if (pop && fifo.size() != 0) void'(fifo.pop_front());
    drive_inputs();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (!(fifo.size() == 0 && busy === 1'b0) && n < 500) begin
      step();
      n++;
    end
    total++;
    if (n >= 500) begin
      bad++;
      $display("FAIL %s_timeout: busy=%b fifo_left=%0d required idle within 500 cycles", name, busy, fifo.size());
    end
  endtask

  task automatic wait_halted(input string name);
    int n = 0;
    while (halted !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s_halt_timeout: halted=%b required 1 within 200 cycles", name, halted);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_error = 1'b0; out_ready = 1'b0;
    fifo.push_back(10'h155);
    drive_inputs();
    step();
    step();
    total += 7;
    if (rx_read_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe: got %b want 0", rx_read_strobe); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", out_data); end
    if (words_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", words_count); end
    if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (reset_strobe_viol != 0) begin bad++; $display("FAIL rst_no_pop: got %0d strobes want 0", reset_strobe_viol); end
    fifo.delete();
    reset = 1'b0;
    model_wc = 0;
    drive_inputs();
    step();
    $display("test_reset done");
  endtask

  task automatic test_single_word();
    int s0 = strobes;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    fifo.push_back(10'h2A5);
    expect_word(10'h2A5, 0);
    drive_inputs();
    drain("single");
    total += 4;
    if (got.size() != 2 || got[0] !== 8'h02 || got[1] !== 8'hA5) begin
      bad++; $display("FAIL single_bytes: got %p want 02 a5", got);
    end
    if (strobes - s0 != 1) begin bad++; $display("FAIL single_strobes: got %0d want 1", strobes - s0); end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL single_count: got %0d want %0d", words_count, model_wc); end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
    $display("test_single_word: bytes=%0d count=%0d", got.size(), words_count);
  endtask

  task automatic test_backpressure();
    int s0 = strobes;
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    fifo.push_back(10'h1FF);
    expect_word(10'h1FF, 0);
    drive_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h01) begin
        bad++; $display("FAIL bp_hold%0d: valid=%b data=%h want valid=1 data=01", i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    drain("bp");
    total += 3;
    if (got.size() != 2 || got[0] !== 8'h01 || got[1] !== 8'hFF) begin
      bad++; $display("FAIL bp_bytes: got %p want 01 ff", got);
    end
    if (strobes - s0 != 1) begin bad++; $display("FAIL bp_strobes: got %0d want 1", strobes - s0); end
    if (stable_viol != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stable_viol); end
    $display("test_backpressure: bytes=%0d", got.size());
  endtask

  task automatic test_burst();
    int s0 = strobes;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      fifo.push_back(10'(i));
      expect_word(10'(i), 0);
    end
    drive_inputs();
    drain("burst");
    total += 4;
    if (got.size() != exp_q.size()) begin bad++; $display("FAIL burst_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL burst_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    if (strobes - s0 != 8) begin bad++; $display("FAIL burst_strobes: got %0d want 8", strobes - s0); end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL burst_count: got %0d want %0d", words_count, model_wc); end
    if (gap_viol != 0) begin bad++; $display("FAIL burst_gap: got %0d back-to-back words want 0", gap_viol); end
    $display("test_burst: bytes=%0d count=%0d", got.size(), words_count);
  endtask

  task automatic test_error();
    int s0 = strobes;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    rx_error = 1'b1; err_code = 10'h001;
    expect_word(10'h001, 1);
    drive_inputs();
    wait_halted("err");
    step();
    step();
    total += 5;
    if (got.size() != 2 || got[0] !== 8'h80 || got[1] !== 8'h01) begin
      bad++; $display("FAIL err_bytes: got %p want 80 01", got);
    end
    if (strobes != s0) begin bad++; $display("FAIL err_strobes: got %0d want 0", strobes - s0); end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL err_count: got %0d want %0d", words_count, model_wc); end
    if (halted !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL err_halt_hold: halted=%b valid=%b want 1 0", halted, out_valid); end
    if (busy !== 1'b1) begin bad++; $display("FAIL err_busy: got %b want 1", busy); end
    rx_error = 1'b0;
    drive_inputs();
    step();
    total++;
    if (halted !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL err_release: halted=%b busy=%b want 0 0", halted, busy); end
    got.delete(); exp_q.delete();
    fifo.push_back(10'h155);
    expect_word(10'h155, 0);
    drive_inputs();
    drain("err_resume");
    total += 2;
    if (got.size() != 2 || got[0] !== 8'h01 || got[1] !== 8'h55) begin
      bad++; $display("FAIL err_resume_bytes: got %p want 01 55", got);
    end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL err_resume_count: got %0d want %0d", words_count, model_wc); end
    $display("test_error: count=%0d", words_count);
  endtask

  task automatic test_error_mid_word();
    int s0 = strobes;
    got.delete(); exp_q.delete();
    out_ready = 1'b0;
    fifo.push_back(10'h3C3);
    expect_word(10'h3C3, 0);
    drive_inputs();
    step();
    rx_error = 1'b1; err_code = 10'h2AB;
    expect_word(10'h2AB, 1);
    drive_inputs();
    step();
    step();
    out_ready = 1'b1;
    wait_halted("mid");
    total += 3;
    if (got.size() != exp_q.size()) begin bad++; $display("FAIL mid_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL mid_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    if (strobes - s0 != 1) begin bad++; $display("FAIL mid_strobes: got %0d want 1", strobes - s0); end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL mid_count: got %0d want %0d", words_count, model_wc); end
    rx_error = 1'b0;
    drive_inputs();
    step();
    $display("test_error_mid_word: bytes=%0d", got.size());
  endtask

  task automatic test_reset_mid_word();
    int s0;
    got.delete(); exp_q.delete();
    out_ready = 1'b1;
    fifo.push_back(10'h0F0);
    drive_inputs();
    step();
    step();
    out_ready = 1'b0;
    reset = 1'b1;
    fifo.push_back(10'h2C7);
    drive_inputs();
    s0 = strobes;
    step();
    total += 4;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    if (words_count !== 16'd0) begin bad++; $display("FAIL rmid_count: got %0d want 0", words_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    if (rx_read_strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe: got %b want 0", rx_read_strobe); end
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    model_wc = 0;
    got.delete(); exp_q.delete();
    expect_word(10'h2C7, 0);
    drive_inputs();
    drain("rmid");
    total += 3;
    if (reset_strobe_viol != 0) begin bad++; $display("FAIL rmid_no_pop: got %0d strobes in reset want 0", reset_strobe_viol); end
    if (got.size() != 2 || got[0] !== 8'h02 || got[1] !== 8'hC7 || strobes - s0 != 1) begin
      bad++; $display("FAIL rmid_resume: got %p strobes=%0d want 02 c7 strobes=1", got, strobes - s0);
    end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL rmid_resume_count: got %0d want %0d", words_count, model_wc); end
    $display("test_reset_mid_word: count=%0d", words_count);
  endtask

  task automatic test_random();
    int s0 = strobes;
    int pushed = 0;
    logic [9:0] w;
    got.delete(); exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (pushed < 40 && $urandom_range(0, 2) == 0) begin
        w = 10'($urandom);
        fifo.push_back(w);
        expect_word(w, 0);
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      drive_inputs();
      step();
    end
    out_ready = 1'b1;
    drive_inputs();
    drain("rand");
    total += 5;
    if (got.size() != exp_q.size()) begin bad++; $display("FAIL rand_len: got %0d want %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got[i], exp_q[i]); end
    end
    if (strobes - s0 != pushed) begin bad++; $display("FAIL rand_strobes: got %0d want %0d", strobes - s0, pushed); end
    if (words_count !== 16'(model_wc)) begin bad++; $display("FAIL rand_count: got %0d want %0d", words_count, model_wc); end
    if (stable_viol != 0 || gap_viol != 0) begin bad++; $display("FAIL rand_protocol: stable=%0d gap=%0d want 0 0", stable_viol, gap_viol); end
    if (strobe_empty_viol != 0) begin bad++; $display("FAIL rand_pop_empty: got %0d want 0", strobe_empty_viol); end
    $display("test_random: words=%0d bytes=%0d count=%0d", pushed, got.size(), words_count);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_error = 1'b0; out_ready = 1'b0; rx_empty = 1'b1; rx_data = '0;
    test_reset();
    test_single_word();
    test_backpressure();
    test_burst();
    test_error();
    test_error_mid_word();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
